seg_scan_capture: RTL and testbench

- Receive-side counterpart of the seven-segment encoder used on the display boards.
- Monitors a multiplexed, active-low seven-segment bus (segment lines plus digit-select lines) and recovers the hex nibble shown on each digit.
- Presents a DIGITS-nibble value word and a one-cycle frame pulse once every digit has been captured.
- Used in loopback self-test and to read external display modules back into the design.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_pattern_to_nibble.sv | 29 ++
 rtl/seg_scan_capture.sv | 156 +++++++++++++++
 tb/tb_seg_scan_capture.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants (active-low, bit order gfedcba) and the
// capture FSM state type, used by both the encoder and the scan capture.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Indexed by nibble value.
  localparam logic [15:0][6:0] SEG_HEX = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg_pattern_to_nibble.sv
// Inverse of the segment encoder table: maps an active-low pattern to a
// nibble, flagging the all-off pattern and anything outside the table.
module seg_pattern_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_err
);

  always_comb begin
    nibble   = 4'd0;
    is_blank = 1'b0;
    is_err   = 1'b1;
    if (seg == SEG_BLANK) begin
      is_blank = 1'b1;
      is_err   = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (seg == SEG_HEX[k]) begin
          nibble = 4'(k);
          is_err = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers the hex digits shown on a multiplexed active-low seven-segment
// bus, capturing each digit only after it has been stable for a while.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  logic [6:0]              s_seg_q, p_seg_q;
  logic [DIGITS-1:0]       s_an_q, p_an_q;
  logic [DIGITS-1:0]       sel;
  logic                    valid, changed, cap;
  cap_state_e              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DIGITS-1:0][3:0]  value_q, value_d;
  logic [DIGITS-1:0]       blank_q, blank_d, err_q, err_d, seen_q, seen_d, seen_nxt;
  logic                    fv_q, fv_d;
  logic [3:0]              nib;
  logic                    is_blank, is_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_seg_q <= SEG_BLANK;
      p_seg_q <= SEG_BLANK;
      s_an_q  <= '1;
      p_an_q  <= '1;
    end else begin
      s_seg_q <= seg;
      p_seg_q <= s_seg_q;
      s_an_q  <= an;
      p_an_q  <= s_an_q;
    end
  end

  assign sel     = ~s_an_q;
  assign valid   = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign changed = {s_an_q, s_seg_q} != {p_an_q, p_seg_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (valid) begin
          state_d = COUNT;
          cnt_d   = 4'd1;
        end
      end
      COUNT: begin
        if (!valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (changed) begin
          cnt_d = 4'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == STABLE_C) begin
            cap     = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (!valid) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (changed) begin
          state_d = COUNT;
          cnt_d   = 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  seg_pattern_to_nibble u_dec (
    .seg      (s_seg_q),
    .nibble   (nib),
    .is_blank (is_blank),
    .is_err   (is_err)
  );

  // sel is one-hot whenever cap is set, so only the driven digit is touched.
  always_comb begin
    value_d  = value_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_d   = seen_q;
    seen_nxt = seen_q | sel;
    fv_d     = 1'b0;
    if (cap) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel[i]) begin
          if (!is_err) value_d[i] = nib;
          blank_d[i] = is_blank;
          err_d[i]   = is_err;
        end
      end
      if (&seen_nxt) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      blank_q <= '0;
      err_q   <= '0;
      seen_q  <= '0;
      fv_q    <= 1'b0;
    end else begin
      value_q <= value_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      fv_q    <= fv_d;
    end
  end

  assign value       = value_q;
  assign blank       = blank_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: latency, full frame, glitch rejection,
// blank/error capture, multi-select rejection and mid-frame reset.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  blank, digit_err;
  logic        frame_valid;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;

  seg_scan_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .blank       (blank),
    .digit_err   (digit_err),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (frame_valid === 1'b1) fv_cnt++;
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    cyc(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    an    = 4'b1111;
    seg   = 7'b1111111;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'b1111;
    seg   = 7'b1111111;
    cyc(2);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_err",   32'(digit_err), 32'h0);
    chk("rst_fv",    32'(frame_valid), 32'h0);
    reset = 1'b0;
    cyc(1);

    // Digit 0 shows "2": no update after 4 edges, update at the 5th.
    drive(4'b1110, 7'b0100100, 4);
    chk("lat_early", 32'(value), 32'h0);
    cyc(1);
    chk("lat_value", 32'(value), 32'h0002);
    chk("lat_blank", 32'(blank), 32'h0);
    chk("lat_err",   32'(digit_err), 32'h0);
    chk("lat_fv",    32'(frame_valid), 32'h0);
    drive(4'b1111, 7'b1111111, 2);

    // Full scan from an empty frame; pulse lands on the digit-0 capture.
    do_reset();
    fv_cnt = 0;
    drive(4'b0111, 7'b0001110, 6);
    drive(4'b1011, 7'b1000000, 6);
    drive(4'b1101, 7'b0000011, 6);
    chk("scan_no_early_fv", 32'(fv_cnt), 32'd0);
    drive(4'b1110, 7'b0011000, 4);
    chk("scan_fv_pre", 32'(frame_valid), 32'h0);
    cyc(1);
    chk("scan_fv_pulse", 32'(frame_valid), 32'h1);
    cyc(1);
    chk("scan_fv_drop", 32'(frame_valid), 32'h0);
    drive(4'b1111, 7'b1111111, 3);
    chk("scan_value",  32'(value), 32'hF0B9);
    chk("scan_fv_cnt", 32'(fv_cnt), 32'd1);

    // Three-sample glitch on digit 1 is rejected.
    fv_cnt = 0;
    drive(4'b1101, 7'b0000000, 3);
    drive(4'b1111, 7'b1111111, 6);
    chk("glitch_value", 32'(value), 32'hF0B9);

    // Digit 2: legal, then blank, then undecodable.
    drive(4'b1011, 7'b0010010, 5);
    chk("d2_five", 32'(value), 32'hF5B9);
    drive(4'b1011, 7'b1111111, 5);
    chk("blank_value", 32'(value), 32'hF0B9);
    chk("blank_bits",  32'(blank), 32'h4);
    chk("blank_err",   32'(digit_err), 32'h0);
    drive(4'b1011, 7'b0101010, 5);
    chk("err_bits",  32'(digit_err), 32'h4);
    chk("err_blank", 32'(blank), 32'h0);
    chk("err_value", 32'(value), 32'hF0B9);
    chk("partial_no_fv", 32'(fv_cnt), 32'd0);

    // Two selects low at once never captures.
    drive(4'b1111, 7'b1111111, 2);
    drive(4'b1100, 7'b0100100, 10);
    chk("multi_value", 32'(value), 32'hF0B9);
    chk("multi_err",   32'(digit_err), 32'h4);
    chk("multi_fv",    32'(fv_cnt), 32'd0);
    drive(4'b1111, 7'b1111111, 2);

    // Reset after two more captures clears everything, including seen.
    drive(4'b1110, 7'b1111001, 5);
    drive(4'b1101, 7'b0110000, 5);
    chk("pre_rst_value", 32'(value), 32'hF031);
    chk("pre_rst_fv",    32'(fv_cnt), 32'd0);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_value", 32'(value), 32'h0);
    chk("mid_rst_blank", 32'(blank), 32'h0);
    chk("mid_rst_err",   32'(digit_err), 32'h0);
    chk("mid_rst_fv",    32'(frame_valid), 32'h0);
    reset = 1'b0;
    an    = 4'b1111;
    seg   = 7'b1111111;
    cyc(2);
    fv_cnt = 0;
    drive(4'b0111, 7'b0000110, 6);
    drive(4'b1011, 7'b0100001, 6);
    drive(4'b1101, 7'b0001000, 6);
    chk("post_rst_no_fv", 32'(fv_cnt), 32'd0);
    drive(4'b1110, 7'b1000110, 6);
    chk("post_rst_fv",    32'(fv_cnt), 32'd1);
    chk("post_rst_value", 32'(value), 32'hEDAC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
